fetch_bundle_queue: RTL and testbench

- Buffers 8-wide fetch bundles (instruction word + final PC per slot) produced by the PC-correction stage.
- Hands up to 2 instructions per cycle, in program order, to the decode stage.
- Decouples wide fetch from narrower decode.
- Supports a full flush on pipeline redirect.

---
 rtl/fetch_bundle_queue.sv | 114 +++++++++++
 tb/tb_fetch_bundle_queue.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_bundle_queue.sv
// fetch_bundle_queue: circular buffer between the 8-wide fetch/PC-correction
// stage and the 2-wide decode stage; accepts whole bundles, releases up to 2.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   flush             drop every entry (redirect); beaten only by reset
//   in_instr, in_pc   8 slots x 32 bits, slot i at [32i+31:32i]
//   in_len            valid slots 0..8 (values above 8 act as 8)
//   in_ready          room for a full 8-slot bundle
//   out_*0 / out_*1   oldest / second-oldest entry, with valids
//   deq_cnt           entries consumed by decode this cycle
//   count             current occupancy
module fetch_bundle_queue #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic [255:0]  in_instr,
    input  logic [255:0]  in_pc,
    input  logic [3:0]    in_len,
    output logic          in_ready,
    output logic [31:0]   out_instr0,
    output logic [31:0]   out_pc0,
    output logic          out_valid0,
    output logic [31:0]   out_instr1,
    output logic [31:0]   out_pc1,
    output logic          out_valid1,
    input  logic [1:0]    deq_cnt,
    output logic [AW:0]   count
);

    localparam int CW = AW + 1;

    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];

    logic [AW-1:0] hd_q, hd_d;
    logic [AW-1:0] tl_q, tl_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [3:0]    n_w;
    logic [1:0]    k_w;
    logic          enq_w;
    logic [AW-1:0] hd1_w;

    // Readiness looks only at registered occupancy, never at this
    // cycle's dequeue, so it is a short path for the fetch stage.
    assign in_ready = (cnt_q <= CW'(DEPTH - 8));

    assign n_w   = (in_len > 4'd8) ? 4'd8 : in_len;
    assign enq_w = in_ready && (n_w != 4'd0);

    // Excess dequeue requests are clipped to what is held.
    always_comb begin
        k_w = deq_cnt;
        if (cnt_q < CW'(deq_cnt)) begin
            k_w = cnt_q[1:0];
        end
    end

    always_comb begin
        hd_d  = hd_q + AW'(k_w);
        tl_d  = tl_q;
        cnt_d = cnt_q - CW'(k_w);
        if (enq_w) begin
            tl_d  = tl_q + AW'(n_w);
            cnt_d = cnt_q + CW'(n_w) - CW'(k_w);
        end
        if (flush) begin
            hd_d  = '0;
            tl_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hd_q  <= '0;
            tl_q  <= '0;
            cnt_q <= '0;
        end else begin
            hd_q  <= hd_d;
            tl_q  <= tl_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage is not reset; only slots below n are written, and
    // nothing is written when the cycle is being discarded.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && enq_w) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < n_w) begin
                    instr_q[tl_q + AW'(i)] <= in_instr[32*i +: 32];
                    pc_q[tl_q + AW'(i)]    <= in_pc[32*i +: 32];
                end
            end
        end
    end

    assign hd1_w = hd_q + AW'(1);

    assign out_instr0 = instr_q[hd_q];
    assign out_pc0    = pc_q[hd_q];
    assign out_instr1 = instr_q[hd1_w];
    assign out_pc1    = pc_q[hd1_w];

    assign out_valid0 = (cnt_q >= CW'(1));
    assign out_valid1 = (cnt_q >= CW'(2));
    assign count      = cnt_q;

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// tb_fetch_bundle_queue: directed bench with a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_fetch_bundle_queue;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [255:0]  in_instr;
    logic [255:0]  in_pc;
    logic [3:0]    in_len;
    logic          in_ready;
    logic [31:0]   out_instr0, out_pc0, out_instr1, out_pc1;
    logic          out_valid0, out_valid1;
    logic [1:0]    deq_cnt;
    logic [4:0]    count;

    int checks = 0;
    int errors = 0;

    fetch_bundle_queue #(.DEPTH(16), .AW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .in_len     (in_len),
        .in_ready   (in_ready),
        .out_instr0 (out_instr0),
        .out_pc0    (out_pc0),
        .out_valid0 (out_valid0),
        .out_instr1 (out_instr1),
        .out_pc1    (out_pc1),
        .out_valid1 (out_valid1),
        .deq_cnt    (deq_cnt),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of {pc, instr} entries.
    logic [63:0] mq[$];
    bit          live = 0;

    function automatic bit m_ready();
        return (16 - mq.size()) >= 8;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            live = 1;
        end else if (flush) begin
            mq.delete();
        end else begin
            int n;
            int k;
            bit rdy;
            rdy = m_ready();
            n = (in_len > 8) ? 8 : int'(in_len);
            k = (int'(deq_cnt) > mq.size()) ? mq.size() : int'(deq_cnt);
            for (int j = 0; j < k; j++) void'(mq.pop_front());
            if (rdy) begin
                for (int j = 0; j < n; j++) begin
                    mq.push_back({in_pc[32*j +: 32], in_instr[32*j +: 32]});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("count", 64'(count), 64'(mq.size()));
            chk("in_ready", 64'(in_ready), 64'(m_ready()));
            chk("valid0", 64'(out_valid0), 64'(mq.size() >= 1));
            chk("valid1", 64'(out_valid1), 64'(mq.size() >= 2));
            if (mq.size() >= 1) begin
                chk("out0", {out_pc0, out_instr0}, mq[0]);
            end
            if (mq.size() >= 2) begin
                chk("out1", {out_pc1, out_instr1}, mq[1]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_bundle(input logic [31:0] pc0,
                              input logic [31:0] ins0);
        for (int i = 0; i < 8; i++) begin
            in_pc[32*i +: 32]    = pc0 + 32'(4 * i);
            in_instr[32*i +: 32] = ins0 + 32'(i);
        end
    endtask

    task automatic drain();
        int b;
        b = 0;
        deq_cnt = 2'd2;
        in_len  = 4'd0;
        while (mq.size() != 0 && b < 20) begin
            tick();
            b++;
        end
        if (mq.size() != 0) chk("drain_timeout", 64'(mq.size()), 64'd0);
        deq_cnt = 2'd0;
    endtask

    int lens[4] = '{3, 5, 8, 8};

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        deq_cnt = 2'd0;
        in_len  = 4'd8;
        set_bundle(32'h900, 32'hE0);
        tick();
        tick();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_v0", 64'(out_valid0), 64'd0);
        chk("rst_v1", 64'(out_valid1), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        rst_n  = 1'b1;
        in_len = 4'd0;
        tick();

        // basic flow
        set_bundle(32'h100, 32'hA0);
        in_len = 4'd8;
        tick();
        in_len = 4'd0;
        chk("bf_pc0", 64'(out_pc0), 64'h100);
        chk("bf_pc1", 64'(out_pc1), 64'h104);
        chk("bf_ins0", 64'(out_instr0), 64'hA0);
        chk("bf_cnt", 64'(count), 64'd8);
        deq_cnt = 2'd2;
        tick();
        chk("bf_p1a", 64'(out_pc0), 64'h108);
        chk("bf_p1b", 64'(out_pc1), 64'h10C);
        tick();
        chk("bf_p2a", 64'(out_pc0), 64'h110);
        chk("bf_p2b", 64'(out_pc1), 64'h114);
        tick();
        chk("bf_p3a", 64'(out_pc0), 64'h118);
        chk("bf_p3b", 64'(out_pc1), 64'h11C);
        chk("bf_i3b", 64'(out_instr1), 64'hA7);
        tick();
        chk("bf_cnt0", 64'(count), 64'd0);
        chk("bf_v0", 64'(out_valid0), 64'd0);
        deq_cnt = 2'd0;

        // backpressure / full
        set_bundle(32'h200, 32'hB0);
        in_len = 4'd8;
        tick();
        set_bundle(32'h220, 32'hB8);
        tick();
        chk("bp_cnt16", 64'(count), 64'd16);
        chk("bp_ready0", 64'(in_ready), 64'd0);
        set_bundle(32'h240, 32'hC0);
        tick();
        chk("bp_ign", 64'(count), 64'd16);
        chk("bp_pc0", 64'(out_pc0), 64'h200);
        in_len  = 4'd0;
        deq_cnt = 2'd2;
        tick();
        chk("bp_cnt14", 64'(count), 64'd14);
        chk("bp_ready14", 64'(in_ready), 64'd0);
        tick();
        tick();
        tick();
        chk("bp_cnt8", 64'(count), 64'd8);
        chk("bp_ready8", 64'(in_ready), 64'd1);
        chk("bp_pc8", 64'(out_pc0), 64'h220);
        drain();

        // wrap with simultaneous enqueue/dequeue
        for (int b = 0; b < 4; b++) begin
            int w;
            bit done;
            w = 0;
            done = 0;
            set_bundle(32'h1000 + 32'(b * 32'h40), 32'h100 + 32'(b * 16));
            in_len  = 4'(lens[b]);
            deq_cnt = 2'd2;
            while (!done && w < 20) begin
                done = m_ready();
                tick();
                w++;
            end
            if (!done) chk("wrap_timeout", 64'd0, 64'd1);
        end
        drain();

        // in_len above 8 acts as 8
        set_bundle(32'h400, 32'hD0);
        in_len = 4'd15;
        tick();
        in_len = 4'd0;
        chk("len15_cnt", 64'(count), 64'd8);
        drain();

        // clipping
        set_bundle(32'h500, 32'hF0);
        in_len = 4'd1;
        tick();
        in_len = 4'd0;
        chk("clip_cnt1", 64'(count), 64'd1);
        chk("clip_v1", 64'(out_valid1), 64'd0);
        deq_cnt = 2'd2;
        tick();
        deq_cnt = 2'd0;
        chk("clip_cnt0", 64'(count), 64'd0);
        chk("clip_v0", 64'(out_valid0), 64'd0);

        // flush priority
        set_bundle(32'h600, 32'h60);
        in_len = 4'd6;
        tick();
        chk("fl_cnt6", 64'(count), 64'd6);
        set_bundle(32'h700, 32'h70);
        in_len  = 4'd8;
        deq_cnt = 2'd2;
        flush   = 1'b1;
        tick();
        flush   = 1'b0;
        in_len  = 4'd0;
        deq_cnt = 2'd0;
        chk("fl_cnt0", 64'(count), 64'd0);
        chk("fl_ready", 64'(in_ready), 64'd1);
        chk("fl_v0", 64'(out_valid0), 64'd0);
        set_bundle(32'h800, 32'h80);
        in_len = 4'd2;
        tick();
        in_len = 4'd0;
        chk("fl_new0", 64'(out_pc0), 64'h800);
        chk("fl_new1", 64'(out_pc1), 64'h804);
        chk("fl_cnt2", 64'(count), 64'd2);

        // reset together with flush mid-operation
        set_bundle(32'hA00, 32'h90);
        in_len = 4'd8;
        tick();
        rst_n = 1'b0;
        flush = 1'b1;
        tick();
        chk("rf_cnt", 64'(count), 64'd0);
        chk("rf_ready", 64'(in_ready), 64'd1);
        chk("rf_v0", 64'(out_valid0), 64'd0);
        chk("rf_v1", 64'(out_valid1), 64'd0);
        rst_n  = 1'b1;
        flush  = 1'b0;
        in_len = 4'd0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
